// File: rtl/hsadc_axis_sampler.sv
// hsadc_axis_sampler: dual-channel high-speed ADC capture framed onto a 16-bit AXI-Stream source
//   clk            system clock
//   rst            asynchronous active-high reset
//   enable         request sampling; a stop is honoured only at a packet boundary
//   channel_a_enc  ADC channel A encode clock
//   channel_b_enc  ADC channel B encode clock (same waveform as channel A)
//   channel_a      ADC channel A data
//   channel_b      ADC channel B data
//   m_axis_tdata   {channel_b, channel_a}
//   m_axis_tvalid  AXIS valid
//   m_axis_tready  AXIS ready
//   m_axis_tlast   last sample of a PACKET_LEN-sample packet
//   overflow_count samples dropped on a full FIFO, saturating
module hsadc_axis_sampler #(
   parameter int CLK_DIV    = 4,
   parameter int PIPE_DELAY = 5,
   parameter int PACKET_LEN = 256,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic        channel_a_enc,
   output logic        channel_b_enc,
   input  logic [7:0]  channel_a,
   input  logic [7:0]  channel_b,
   output logic [15:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic [15:0] overflow_count
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int FW = PIPE_DELAY > 1 ? $clog2(PIPE_DELAY) : 1;
   localparam int PW = PACKET_LEN > 1 ? $clog2(PACKET_LEN) : 1;
   localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FLUSH = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;

   logic [1:0]    state, state_nx;
   logic [DW-1:0] div_cnt, div_nx;
   logic [FW-1:0] flush_cnt;
   logic [PW-1:0] pkt_cnt;
   logic [15:0]   pin_q;
   logic          enc;
   logic [16:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          strobe, pop, push, drop, last;

   assign channel_a_enc = enc;
   assign channel_b_enc = enc;
   assign strobe = state != IDLE && div_cnt == DW'(CLK_DIV - 1);
   assign m_axis_tvalid = count != '0;
   assign pop = m_axis_tvalid && m_axis_tready;
   // a full FIFO still accepts when a beat leaves in the same cycle
   assign push = strobe && state == RUN && (count != (AW + 1)'(FIFO_DEPTH) || pop);
   assign drop = strobe && state == RUN && !push;
   assign last = pkt_cnt == PW'(PACKET_LEN - 1);
   // gating with tvalid keeps tdata/tlast at zero whenever the FIFO is empty, including right after reset
   assign {m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? mem[rd_ptr] : '0;

   always_comb begin
      state_nx = state;
      if (state == IDLE && enable)
         state_nx = PIPE_DELAY == 0 ? RUN : FLUSH;
      else if (state == FLUSH && strobe && flush_cnt == FW'(PIPE_DELAY - 1))
         state_nx = RUN;
      else if (push && last && !enable)
         state_nx = IDLE;
      div_nx = (state == IDLE || div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pin_q          <= '0;
         state          <= IDLE;
         div_cnt        <= '0;
         enc            <= 1'b0;
         flush_cnt      <= '0;
         pkt_cnt        <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         overflow_count <= '0;
      end else begin
         pin_q   <= {channel_b, channel_a};
         state   <= state_nx;
         div_cnt <= div_nx;
         // registered from next-state values so the pin tracks the current div_cnt phase
         enc     <= state_nx != IDLE && div_nx < DW'(CLK_DIV / 2);
         if (state == IDLE)
            flush_cnt <= '0;
         else if (state == FLUSH && strobe)
            flush_cnt <= flush_cnt + 1'b1;
         if (push) begin
            wr_ptr  <= wr_ptr == AW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            pkt_cnt <= last ? '0 : pkt_cnt + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr == AW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
         count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
         if (drop && overflow_count != 16'hFFFF)
            overflow_count <= overflow_count + 1'b1;
      end
   end

   always_ff @(posedge clk)
      if (push)
         mem[wr_ptr] <= {last, pin_q};
endmodule

// File: tb/tb_hsadc_axis_sampler.sv
// tb_hsadc_axis_sampler: directed checks of framing, overflow, stop, stall and async reset
module tb_hsadc_axis_sampler;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        m_axis_tready = 1'b0;
   logic        channel_a_enc, channel_b_enc, m_axis_tvalid, m_axis_tlast;
   logic [7:0]  channel_a = '0;
   logic [7:0]  channel_b = '0;
   logic [15:0] m_axis_tdata, overflow_count;
   logic [7:0]  pin_val = 8'hFF;
   logic        enc_prev = 1'b0;
   logic        rand_ready = 1'b0;
   logic [15:0] got_d[$];
   logic        got_l[$];
   int          checks = 0;
   int          errors = 0;

   hsadc_axis_sampler #(.CLK_DIV(4), .PIPE_DELAY(2), .PACKET_LEN(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .channel_a_enc(channel_a_enc), .channel_b_enc(channel_b_enc),
      .channel_a(channel_a), .channel_b(channel_b),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .overflow_count(overflow_count)
   );

   always #5 clk = ~clk;

   // one clock: log the handshake at the edge, then ramp the pins at each encode rising edge
   task automatic step();
      if (m_axis_tvalid && m_axis_tready) begin
         got_d.push_back(m_axis_tdata);
         got_l.push_back(m_axis_tlast);
      end
      @(posedge clk);
      #1;
      if (channel_a_enc && !enc_prev)
         pin_val = pin_val + 8'd1;
      enc_prev = channel_a_enc;
      channel_a = pin_val;
      channel_b = pin_val;
      if (rand_ready)
         m_axis_tready = $urandom_range(0, 99) < 30;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      enable = 1'b0;
      m_axis_tready = 1'b0;
      rand_ready = 1'b0;
      pin_val = 8'hFF;
      enc_prev = 1'b0;
      step();
      step();
      rst = 1'b0;
      got_d.delete();
      got_l.delete();
   endtask

   task automatic collect(input int n);
      for (int i = 0; i < 400 && got_d.size() < n; i++)
         step();
      checks++;
      if (got_d.size() < n) begin
         errors++;
         $display("FAIL collect_timeout: got %0d beats want %0d", got_d.size(), n);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({channel_a_enc, channel_b_enc, m_axis_tvalid, m_axis_tlast} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0000", {channel_a_enc, channel_b_enc, m_axis_tvalid, m_axis_tlast});
      end
      checks++;
      if (m_axis_tdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_tdata: got %h want 0000", m_axis_tdata);
      end
      checks++;
      if (overflow_count !== 16'h0) begin
         errors++;
         $display("FAIL reset_overflow: got %h want 0000", overflow_count);
      end
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (channel_a_enc !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: got enc=%b tvalid=%b want 0 0", channel_a_enc, m_axis_tvalid);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] k;
      do_reset();
      m_axis_tready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 13; i++) begin
         step();
         if (i < 8) begin
            checks++;
            if (channel_a_enc !== ((i % 4) < 2) || channel_b_enc !== ((i % 4) < 2)) begin
               errors++;
               $display("FAIL basic_enc%0d: got a=%b b=%b want %b", i, channel_a_enc, channel_b_enc, (i % 4) < 2);
            end
         end
         if (i == 11) begin
            checks++;
            if (m_axis_tvalid !== 1'b0) begin
               errors++;
               $display("FAIL basic_early_valid: got %b want 0", m_axis_tvalid);
            end
         end
      end
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0202) begin
         errors++;
         $display("FAIL basic_first: got v=%b d=%h want 1 0202", m_axis_tvalid, m_axis_tdata);
      end
      collect(12);
      for (int i = 0; i < 12 && i < got_d.size(); i++) begin
         k = 8'(2 + i);
         checks++;
         if (got_d[i] !== {k, k} || got_l[i] !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], {k, k}, i % 4 == 3);
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_v [12] = '{2, 3, 4, 5, 9, 10, 11, 12, 13, 14, 15, 16};
      do_reset();
      enable = 1'b1;
      repeat (37) step();
      checks++;
      if (overflow_count !== 16'd3) begin
         errors++;
         $display("FAIL ovf_count: got %0d want 3", overflow_count);
      end
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0202) begin
         errors++;
         $display("FAIL ovf_head: got v=%b d=%h want 1 0202", m_axis_tvalid, m_axis_tdata);
      end
      m_axis_tready = 1'b1;
      collect(12);
      for (int i = 0; i < 12 && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== {exp_v[i], exp_v[i]} || got_l[i] !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL ovf_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], {exp_v[i], exp_v[i]}, i % 4 == 3);
         end
      end
      checks++;
      if (overflow_count !== 16'd3) begin
         errors++;
         $display("FAIL ovf_final: got %0d want 3", overflow_count);
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] k;
      do_reset();
      enable = 1'b1;
      repeat (28) step();
      checks++;
      if (m_axis_tvalid !== 1'b1 || overflow_count !== 16'd0) begin
         errors++;
         $display("FAIL fullpop_pre: got v=%b ovf=%0d want 1 0", m_axis_tvalid, overflow_count);
      end
      m_axis_tready = 1'b1;
      step();
      checks++;
      if (overflow_count !== 16'd0) begin
         errors++;
         $display("FAIL fullpop_ovf: got %0d want 0", overflow_count);
      end
      collect(8);
      for (int i = 0; i < 8 && i < got_d.size(); i++) begin
         k = 8'(2 + i);
         checks++;
         if (got_d[i] !== {k, k} || got_l[i] !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL fullpop_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], {k, k}, i % 4 == 3);
         end
      end
   endtask

   task automatic test_stop();
      logic [7:0] k;
      do_reset();
      m_axis_tready = 1'b1;
      enable = 1'b1;
      repeat (17) step();
      enable = 1'b0;
      for (int j = 17; j < 57; j++) begin
         step();
         if (j >= 24) begin
            checks++;
            if (channel_a_enc !== 1'b0 || channel_b_enc !== 1'b0) begin
               errors++;
               $display("FAIL stop_enc_c%0d: got %b%b want 00", j, channel_a_enc, channel_b_enc);
            end
         end
      end
      checks++;
      if (got_d.size() != 4) begin
         errors++;
         $display("FAIL stop_count: got %0d beats want 4", got_d.size());
      end
      for (int i = 0; i < 4 && i < got_d.size(); i++) begin
         k = 8'(2 + i);
         checks++;
         if (got_d[i] !== {k, k} || got_l[i] !== (i == 3)) begin
            errors++;
            $display("FAIL stop_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], {k, k}, i == 3);
         end
      end
      enable = 1'b1;
      for (int j = 0; j < 13; j++) begin
         step();
         if (j == 11) begin
            checks++;
            if (m_axis_tvalid !== 1'b0) begin
               errors++;
               $display("FAIL restart_early_valid: got %b want 0", m_axis_tvalid);
            end
         end
      end
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0808) begin
         errors++;
         $display("FAIL restart_first: got v=%b d=%h want 1 0808", m_axis_tvalid, m_axis_tdata);
      end
      collect(8);
      for (int i = 4; i < 8 && i < got_d.size(); i++) begin
         k = 8'(4 + i);
         checks++;
         if (got_d[i] !== {k, k} || got_l[i] !== (i == 7)) begin
            errors++;
            $display("FAIL restart_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], {k, k}, i == 7);
         end
      end
   endtask

   task automatic test_stall();
      logic        hold, l;
      logic [15:0] d;
      int          gaps;
      do_reset();
      rand_ready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 500; i++) begin
         hold = m_axis_tvalid && !m_axis_tready;
         d = m_axis_tdata;
         l = m_axis_tlast;
         if (i == 300)
            enable = 1'b0;
         step();
         if (hold) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d || m_axis_tlast !== l) begin
               errors++;
               $display("FAIL stall_hold%0d: got v=%b d=%h l=%b want 1 %h %b", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, d, l);
            end
         end
      end
      rand_ready = 1'b0;
      m_axis_tready = 1'b1;
      repeat (60) step();
      checks++;
      if (got_d.size() == 0 || got_d.size() % 4 != 0) begin
         errors++;
         $display("FAIL stall_count: got %0d beats want nonzero multiple of 4", got_d.size());
      end
      if (got_d.size() > 0) begin
         checks++;
         if (got_d[0] !== 16'h0202) begin
            errors++;
            $display("FAIL stall_first: got %h want 0202", got_d[0]);
         end
      end
      gaps = 0;
      for (int i = 0; i < got_d.size(); i++) begin
         checks++;
         if (got_l[i] !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL stall_tlast%0d: got %b want %b", i, got_l[i], i % 4 == 3);
         end
         if (i > 0) begin
            checks++;
            if (got_d[i][7:0] <= got_d[i-1][7:0] || got_d[i][15:8] !== got_d[i][7:0]) begin
               errors++;
               $display("FAIL stall_order%0d: got %h after %h want increasing", i, got_d[i], got_d[i-1]);
            end
            gaps += int'(got_d[i][7:0]) - int'(got_d[i-1][7:0]) - 1;
         end
      end
      checks++;
      if (int'(overflow_count) != gaps) begin
         errors++;
         $display("FAIL stall_gaps: got overflow %0d want %0d", overflow_count, gaps);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      m_axis_tready = 1'b1;
      enable = 1'b1;
      repeat (17) step();
      checks++;
      if (m_axis_tvalid !== 1'b1 || channel_a_enc !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: got v=%b enc=%b want 1 1", m_axis_tvalid, channel_a_enc);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({channel_a_enc, channel_b_enc, m_axis_tvalid, m_axis_tlast} !== 4'b0) begin
         errors++;
         $display("FAIL areset_flags: got %b want 0000", {channel_a_enc, channel_b_enc, m_axis_tvalid, m_axis_tlast});
      end
      checks++;
      if (m_axis_tdata !== 16'h0 || overflow_count !== 16'h0) begin
         errors++;
         $display("FAIL areset_data: got d=%h ovf=%h want 0000 0000", m_axis_tdata, overflow_count);
      end
      got_d.delete();
      got_l.delete();
      step();
      step();
      rst = 1'b0;
      collect(1);
      if (got_d.size() > 0) begin
         checks++;
         if (got_d[0] !== 16'h0707 || got_l[0] !== 1'b0) begin
            errors++;
            $display("FAIL areset_first: got %h/%b want 0707/0", got_d[0], got_l[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_pop();
      test_stop();
      test_stall();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
